// File: rtl/host_rx_pkg.sv
// Shared constants for the host command receive front end: opcodes, error codes,
// packet byte offsets, frame field positions and the sequencer state encoding.
package host_rx_pkg;

    localparam int ENTRY_W = 72;

    localparam logic [7:0] OP_ENCRYPT_CFG = 8'h01;
    localparam logic [7:0] OP_READ        = 8'h03;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TARGET  = 3'd1;
    localparam logic [2:0] ERR_SIZE    = 3'd2;
    localparam logic [2:0] ERR_CHANNEL = 3'd3;
    localparam logic [2:0] ERR_OPCODE  = 3'd4;

    localparam int BYTE_OPCODE  = 0;
    localparam int BYTE_TARGET  = 1;
    localparam int BYTE_LEN     = 7;
    localparam int BYTE_PAYLOAD = 8;

    localparam int FRM_OPCODE_LSB  = 0;
    localparam int FRM_TARGET_LSB  = 8;
    localparam int FRM_CHANNEL_LSB = 56;
    localparam int FRM_ERR_LSB     = 64;
    localparam int FRM_ENC_BIT     = 72;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic [7:0] pkt_byte(input logic [ENTRY_W-1:0] pkt, input int idx);
        return pkt[8*idx +: 8];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/host_rx_fifo.sv
// Small synchronous FIFO holding the stored 72-bit packet prefixes.
// Head entry is presented combinationally on rdata while not empty.
module host_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 72
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/host_cmd_rx_param.sv
// Host command receive front end: queues packets, decodes/checks them, keeps the
// per-channel encrypt mask and emits one frame per packet. HOST_RX_STATS_EN adds counters.
module host_cmd_rx_param #(
    parameter int IN_W       = 1024,
    parameter int OUT_W      = 144,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   input_data,
    input  logic              send_packet,
    output logic              in_ready,
    output logic [OUT_W-1:0]  encoded_output,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_CH-1:0] encrypt_decrypt_passthrough,
    output logic              error,
    output logic [2:0]        error_code,
    output logic              done,
    output logic              overflow,
    output logic [1:0]        dbg_state
`ifdef HOST_RX_STATS_EN
    ,
    output logic [15:0]       stat_ok,
    output logic [15:0]       stat_err,
    output logic [15:0]       stat_drop
`endif
);
    import host_rx_pkg::*;

    // Handshakes: a packet enters when send_packet && in_ready at a rising edge; a frame
    // leaves when out_valid && out_ready at a rising edge, and the frame is held stable until then.
    state_e              state_q, state_d;
    logic [ENTRY_W-1:0]  pkt_q, pkt_d;
    logic [NUM_CH-1:0]   enc_q, enc_d;
    logic [OUT_W-1:0]    frame_q, frame_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [2:0]          error_code_q, error_code_d;
    logic                overflow_q, overflow_d;

    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [ENTRY_W-1:0]  fifo_rdata;
    logic                unused_bits;

    assign fifo_push   = send_packet && !fifo_full;
    assign unused_bits = ^{input_data, pkt_q};

    host_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (fifo_push),
        .wdata (input_data[ENTRY_W-1:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    logic [7:0]        opcode, len_field, dec_channel;
    logic [47:0]       target;
    logic [2:0]        dec_code;
    logic [NUM_CH-1:0] enc_next;
    logic              enc_bit;
    logic [OUT_W-1:0]  dec_frame;

    always_comb begin
        opcode      = pkt_byte(pkt_q, BYTE_OPCODE);
        len_field   = pkt_byte(pkt_q, BYTE_LEN);
        target      = pkt_q[8*BYTE_TARGET +: 48];
        dec_code    = ERR_NONE;
        dec_channel = '0;
        enc_next    = enc_q;
        enc_bit     = 1'b0;
        case (opcode)
            OP_ENCRYPT_CFG: begin
                if (target != '1)              dec_code = ERR_TARGET;
                else if (len_field != 8'h01)   dec_code = ERR_SIZE;
                else                           enc_next = pkt_q[8*BYTE_PAYLOAD +: NUM_CH];
            end
            OP_READ: begin
                dec_channel = len_field;
                if (len_field >= 8'(NUM_CH)) dec_code = ERR_CHANNEL;
            end
            default: dec_code = ERR_OPCODE;
        endcase
        // Out-of-range channels match no mask bit and report 0.
        for (int i = 0; i < NUM_CH; i++) begin
            if (dec_channel == 8'(i)) enc_bit = enc_next[i];
        end
        dec_frame = '0;
        dec_frame[FRM_OPCODE_LSB +: 8]  = opcode;
        dec_frame[FRM_TARGET_LSB +: 48] = target;
        dec_frame[FRM_CHANNEL_LSB +: 8] = dec_channel;
        dec_frame[FRM_ERR_LSB +: 8]     = {5'b0, dec_code};
        dec_frame[FRM_ENC_BIT]          = enc_bit;
    end

    always_comb begin
        state_d      = state_q;
        pkt_d        = pkt_q;
        enc_d        = enc_q;
        frame_d      = frame_q;
        out_valid_d  = out_valid_q;
        done_d       = 1'b0;
        error_d      = error_q;
        error_code_d = error_code_q;
        fifo_pop     = 1'b0;
        overflow_d   = overflow_q | (send_packet & fifo_full);
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    pkt_d    = fifo_rdata;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                enc_d        = enc_next;
                frame_d      = dec_frame;
                error_d      = (dec_code != ERR_NONE);
                error_code_d = dec_code;
                out_valid_d  = 1'b1;
                state_d      = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    error_d      = 1'b0;
                    error_code_d = ERR_NONE;
                    done_d       = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pkt_q        <= '0;
            enc_q        <= '0;
            frame_q      <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            error_code_q <= ERR_NONE;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pkt_q        <= pkt_d;
            enc_q        <= enc_d;
            frame_q      <= frame_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            error_q      <= error_d;
            error_code_q <= error_code_d;
            overflow_q   <= overflow_d;
        end
    end

    assign in_ready                    = !fifo_full;
    assign encoded_output              = frame_q;
    assign out_valid                   = out_valid_q;
    assign encrypt_decrypt_passthrough = enc_q;
    assign error                       = error_q;
    assign error_code                  = error_code_q;
    assign done                        = done_q;
    assign overflow                    = overflow_q;
    assign dbg_state                   = state_q;

`ifdef HOST_RX_STATS_EN
    logic [15:0] stat_ok_q, stat_ok_d, stat_err_q, stat_err_d, stat_drop_q, stat_drop_d;

    // The emitted frame is still held in frame_q during DONE, so its error field decides.
    always_comb begin
        stat_ok_d   = stat_ok_q;
        stat_err_d  = stat_err_q;
        stat_drop_d = stat_drop_q;
        if (state_q == ST_DONE) begin
            if (frame_q[FRM_ERR_LSB +: 3] == ERR_NONE) stat_ok_d  = sat_inc16(stat_ok_q);
            else                                       stat_err_d = sat_inc16(stat_err_q);
        end
        if (send_packet && fifo_full) stat_drop_d = sat_inc16(stat_drop_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_ok_q   <= '0;
            stat_err_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_ok_q   <= stat_ok_d;
            stat_err_q  <= stat_err_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_ok   = stat_ok_q;
    assign stat_err  = stat_err_q;
    assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_host_cmd_rx_param.sv
// Directed bench for host_cmd_rx_param: packet-order model plus per-cycle output compare.
module tb_host_cmd_rx_param;
  localparam int IN_W       = 1024;
  localparam int OUT_W      = 144;
  localparam int NUM_CH     = 4;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [IN_W-1:0]   input_data;
  logic              send_packet;
  logic              in_ready;
  logic [OUT_W-1:0]  encoded_output;
  logic              out_valid;
  logic              out_ready;
  logic [NUM_CH-1:0] enc_mask;
  logic              error;
  logic [2:0]        error_code;
  logic              done;
  logic              overflow;
  logic [1:0]        dbg_state;
`ifdef HOST_RX_STATS_EN
  logic [15:0]       stat_ok, stat_err, stat_drop;
`endif

  always #5 clk = ~clk;

  host_cmd_rx_param #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk                         (clk),
    .reset                       (rst_n),
    .input_data                  (input_data),
    .send_packet                 (send_packet),
    .in_ready                    (in_ready),
    .encoded_output              (encoded_output),
    .out_valid                   (out_valid),
    .out_ready                   (out_ready),
    .encrypt_decrypt_passthrough (enc_mask),
    .error                       (error),
    .error_code                  (error_code),
    .done                        (done),
    .overflow                    (overflow),
    .dbg_state                   (dbg_state)
`ifdef HOST_RX_STATS_EN
    ,
    .stat_ok                     (stat_ok),
    .stat_err                    (stat_err),
    .stat_drop                   (stat_drop)
`endif
  );

  typedef struct packed {
    logic [OUT_W-1:0]  frame;
    logic [2:0]        code;
    logic [NUM_CH-1:0] mask;
  } exp_t;

  exp_t              exp_q[$];
  logic [NUM_CH-1:0] m_mask;
  int                errors = 0;
  int                checks = 0;
  int                model_drops = 0;
  bit                in_reset = 1'b1;
  bit                exp_done = 1'b0;

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Frame contents follow from the packet bytes and the mask left by earlier packets.
  task automatic model_accept(input logic [71:0] p);
    exp_t       e;
    logic [7:0] b [9];
    bit         all_ff;
    int         ch;
    for (int i = 0; i < 9; i++) b[i] = p[8*i +: 8];
    e.code = 3'd0;
    ch = 0;
    if (b[0] == 8'h01) begin
      all_ff = 1'b1;
      for (int i = 1; i <= 6; i++) if (b[i] != 8'hFF) all_ff = 1'b0;
      if (!all_ff)           e.code = 3'd1;
      else if (b[7] != 8'h01) e.code = 3'd2;
      else                   m_mask = b[8][NUM_CH-1:0];
    end else if (b[0] == 8'h03) begin
      ch = int'(b[7]);
      if (ch >= NUM_CH) e.code = 3'd3;
    end else begin
      e.code = 3'd4;
    end
    e.mask          = m_mask;
    e.frame         = '0;
    e.frame[7:0]    = b[0];
    e.frame[55:8]   = p[55:8];
    e.frame[63:56]  = 8'(ch);
    e.frame[71:64]  = {5'd0, e.code};
    e.frame[72]     = (ch < NUM_CH) ? m_mask[ch] : 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [71:0] p, output bit accepted);
    logic [IN_W-1:0] d;
    for (int i = 0; i < IN_W/32; i++) d[32*i +: 32] = $urandom;
    d[71:0]     = p;
    input_data  = d;
    send_packet = 1'b1;
    accepted    = in_ready;
    if (accepted) model_accept(p);
    else          model_drops++;
    @(posedge clk);
    #1;
    send_packet = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s: out_valid never rose within 40 cycles", name);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !out_valid && !done) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s: %0d frames still outstanding after 300 cycles", name, exp_q.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  OUT_W'(in_ready),   1);
    check({tag, "_out_valid"}, OUT_W'(out_valid),  0);
    check({tag, "_done"},      OUT_W'(done),       0);
    check({tag, "_error"},     OUT_W'(error),      0);
    check({tag, "_err_code"},  OUT_W'(error_code), 0);
    check({tag, "_frame"},     encoded_output,     0);
    check({tag, "_mask"},      OUT_W'(enc_mask),   0);
    check({tag, "_overflow"},  OUT_W'(overflow),   0);
`ifdef HOST_RX_STATS_EN
    check({tag, "_stat_ok"},   OUT_W'(stat_ok),    0);
    check({tag, "_stat_err"},  OUT_W'(stat_err),   0);
    check({tag, "_stat_drop"}, OUT_W'(stat_drop),  0);
`endif
  endtask

  // Per-cycle compare against the model queue, sampled mid-cycle.
  always @(negedge clk) begin
    if (!in_reset) begin
      check("done_pulse", OUT_W'(done), OUT_W'(exp_done));
      exp_done = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %0h expected no frame", encoded_output);
        end else begin
          check("frame",      encoded_output,       exp_q[0].frame);
          check("error",      OUT_W'(error),        OUT_W'(exp_q[0].code != 3'd0));
          check("error_code", OUT_W'(error_code),   OUT_W'(exp_q[0].code));
          check("mask",       OUT_W'(enc_mask),     OUT_W'(exp_q[0].mask));
          if (out_ready) begin
            void'(exp_q.pop_front());
            exp_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          n_acc;
    logic [71:0] ovf_pkts [6];
    ovf_pkts = '{72'h0000AABBCCDDEEFF03, 72'h0003123456789ABC03, 72'h0005FFFFFFFFFFFF01,
                 72'h0002000000000000003, 72'h0001CAFEF00DBEEF03, 72'h000000000000000007};

    rst_n       = 1'b0;
    input_data  = '0;
    send_packet = 1'b0;
    out_ready   = 1'b0;
    m_mask      = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("reset");
    in_reset = 1'b0;

    // Encrypt config accepted, latency probe with the sink stalled.
    send_pkt(72'h0101FFFFFFFFFFFF01, acc);
    check("lat_edge0", OUT_W'(out_valid), 0);
    tick();
    check("lat_edge1", OUT_W'(out_valid), 0);
    tick();
    tick();
    check("lat_edge3", OUT_W'(out_valid), 1);
    check("cfg_opcode", OUT_W'(encoded_output[7:0]), 8'h01);
    check("cfg_error",  OUT_W'(error), 0);
    check("cfg_mask",   OUT_W'(enc_mask), 4'b0001);
    out_ready = 1'b1;
    tick();
    check("cfg_done",   OUT_W'(done), 1);
    check("cfg_valid_drop", OUT_W'(out_valid), 0);
    tick();
    check("cfg_done_one_cycle", OUT_W'(done), 0);

    // Target and size errors leave the mask alone.
    send_pkt(72'h0001FFFFFF27FFFF01, acc);
    send_pkt(72'h0002FFFFFFFFFFFF01, acc);
    wait_valid("err_target");
    check("err_target_code", OUT_W'(error_code), 1);
    check("err_target_flag", OUT_W'(error), 1);
    check("err_target_mask", OUT_W'(enc_mask), 4'b0001);
    tick();
    wait_valid("err_size");
    check("err_size_code", OUT_W'(error_code), 2);
    tick();

    // Read forwards the target and reports the channel's encrypt bit.
    send_pkt(72'h00FF27FF27FF2703, acc);
    wait_valid("read_ch0");
    check("read_target", OUT_W'(encoded_output[55:8]), 48'hFF27FF27FF27);
    check("read_channel", OUT_W'(encoded_output[63:56]), 0);
    check("read_bit72", OUT_W'(encoded_output[72]), 1);
    check("read_error", OUT_W'(error), 0);
    tick();

    send_pkt(72'h00FF27FF27FF2705, acc);
    send_pkt(72'h0004FF27FF27FF2703, acc);
    wait_valid("bad_opcode");
    check("bad_opcode_code", OUT_W'(error_code), 4);
    tick();
    wait_valid("bad_channel");
    check("bad_channel_code", OUT_W'(error_code), 3);
    check("bad_channel_field", OUT_W'(encoded_output[63:56]), 8'h04);
    tick();

    // A read queued right behind a config sees the new mask.
    send_pkt(72'h0A01FFFFFFFFFFFF01, acc);
    send_pkt(72'h0001112233445566_03, acc);
    wait_valid("chain_cfg");
    tick();
    wait_valid("chain_read");
    check("chain_bit72", OUT_W'(encoded_output[72]), 1);
    check("chain_mask", OUT_W'(enc_mask), 4'b1010);
    drain("directed");

    // Stalled sink with six back-to-back packets: one is dropped.
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      send_pkt(ovf_pkts[i], acc);
      if (acc) n_acc++;
    end
    check("ovf_accepted", OUT_W'(n_acc), 5);
    check("ovf_in_ready", OUT_W'(in_ready), 0);
    check("ovf_flag", OUT_W'(overflow), 1);
`ifdef HOST_RX_STATS_EN
    check("ovf_stat_drop", OUT_W'(stat_drop), 1);
`endif
    out_ready = 1'b1;
    drain("overflow");
    check("ovf_sticky", OUT_W'(overflow), 1);

    // Reset asserted while a frame is being presented.
    out_ready = 1'b0;
    send_pkt(72'h0000010203040506_03, acc);
    send_pkt(72'h0002010203040506_03, acc);
    wait_valid("pre_reset");
    in_reset = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    m_mask   = '0;
    exp_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    in_reset  = 1'b0;
    out_ready = 1'b1;
    send_pkt(72'h0000ABCDEF012345_03, acc);
    wait_valid("post_reset");
    check("post_reset_bit72", OUT_W'(encoded_output[72]), 0);
    check("post_reset_target", OUT_W'(encoded_output[55:8]), 48'hABCDEF012345);
    drain("post_reset");
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        checks++;
        errors++;
        $display("FAIL lost_queue: got out_valid=1 expected 0 at idle cycle %0d", i);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
